// File: rtl/dot_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_ram_ctrl_if
// Brief    : ROM/RAM, video, eat and status signals of the dot map controller.
// Revision : 1.0 - initial release
// ============================================================================
interface dot_ram_ctrl_if #(
   parameter int COLS    = 28,
   parameter int SCORE_W = 20
);
   logic                 level_start;
   logic [4:0]           rom_addr;
   logic [2*COLS-1:0]    rom_data;
   logic [4:0]           mem_addr;
   logic                 mem_we;
   logic [2*COLS-1:0]    mem_wdata;
   logic [2*COLS-1:0]    mem_rdata;
   logic                 vid_req;
   logic [4:0]           vid_row;
   logic                 vid_rvalid;
   logic [2*COLS-1:0]    vid_rdata;
   logic                 eat_valid;
   logic [4:0]           eat_row;
   logic [4:0]           eat_col;
   logic                 eat_ready;
   logic [SCORE_W-1:0]   score;
   logic [9:0]           dots_left;
   logic                 level_clear;
   logic                 pellet_eaten;
   logic                 init_busy;

   // Controller side
   modport slave (
      input  level_start, rom_data, mem_rdata, vid_req, vid_row,
             eat_valid, eat_row, eat_col,
      output rom_addr, mem_addr, mem_we, mem_wdata, vid_rvalid, vid_rdata,
             eat_ready, score, dots_left, level_clear, pellet_eaten, init_busy
   );

   // Game / memory side
   modport master (
      output level_start, rom_data, mem_rdata, vid_req, vid_row,
             eat_valid, eat_row, eat_col,
      input  rom_addr, mem_addr, mem_we, mem_wdata, vid_rvalid, vid_rdata,
             eat_ready, score, dots_left, level_clear, pellet_eaten, init_busy
   );
endinterface
`default_nettype wire

// File: rtl/dot_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dot_ram_ctrl
// Brief    : Maze dot map RAM sequencer: level load, video reads, eat RMW, score.
// Revision : 1.0 - initial release
// ============================================================================
module dot_ram_ctrl #(
   parameter int ROWS         = 31,
   parameter int COLS         = 28,
   parameter int DOT_VALUE    = 10,
   parameter int PELLET_VALUE = 50,
   parameter int SCORE_W      = 20
) (
   input  logic          Clk,
   input  logic          Reset,
   dot_ram_ctrl_if.slave bus
);
   localparam int c_DATA_W = 2*COLS;
   localparam int c_IDX_W  = $clog2(c_DATA_W);

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_IDLE = 3'd1,
      ST_RD   = 3'd2,
      ST_MOD  = 3'd3,
      ST_WR   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [5:0]            r_init_cnt;
   logic [4:0]            r_eat_row;
   logic [4:0]            r_eat_col;
   logic [c_DATA_W-1:0]   r_row_data;
   logic                  r_pellet;
   logic [SCORE_W-1:0]    r_score;
   logic [9:0]            r_dots_left;
   logic                  r_level_clear;
   logic                  r_pellet_eaten;
   logic                  r_vid_rvalid;

   logic [4:0]            w_mem_addr;
   logic                  w_mem_we;
   logic [c_DATA_W-1:0]   w_mem_wdata;
   logic                  w_init_write;
   logic                  w_eat_write;
   logic                  w_accept;
   logic                  w_in_range;
   logic [c_IDX_W-1:0]    w_idx_lo;
   logic [c_IDX_W-1:0]    w_idx_hi;
   logic                  w_cell_pellet;
   logic                  w_cell_dot;
   logic [c_DATA_W-1:0]   w_clr_mask;
   logic [9:0]            w_row_pop;
   logic [SCORE_W-1:0]    w_add;
   logic [SCORE_W:0]      w_sum;
   logic [SCORE_W-1:0]    w_score_nxt;

   // Column 0 sits at the MSB of each half of the row word
   assign w_idx_lo      = c_IDX_W'(COLS-1) - c_IDX_W'(r_eat_col);
   assign w_idx_hi      = w_idx_lo + c_IDX_W'(COLS);
   assign w_cell_pellet = bus.mem_rdata[w_idx_hi];
   assign w_cell_dot    = bus.mem_rdata[w_idx_lo];
   assign w_clr_mask    = ~((c_DATA_W'(1) << w_idx_lo) | (c_DATA_W'(1) << w_idx_hi));
   assign w_in_range    = (int'(bus.eat_row) < ROWS) && (int'(bus.eat_col) < COLS);

   assign w_add       = r_pellet ? SCORE_W'(PELLET_VALUE) : SCORE_W'(DOT_VALUE);
   assign w_sum       = {1'b0, r_score} + {1'b0, w_add};
   assign w_score_nxt = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

   always_comb begin
      w_row_pop = '0;
      for (int i = 0; i < COLS; i++) begin
         w_row_pop = w_row_pop + {9'd0, (bus.rom_data[i] | bus.rom_data[COLS+i])};
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mem_addr   = '0;
      w_mem_we     = 1'b0;
      w_mem_wdata  = '0;
      w_init_write = 1'b0;
      w_eat_write  = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         ST_INIT: begin
            // ROM data lags its address by one cycle, so row k lands at count k+1
            if (r_init_cnt != 6'd0) begin
               w_init_write = 1'b1;
               w_mem_we     = 1'b1;
               w_mem_addr   = 5'(r_init_cnt - 6'd1);
               w_mem_wdata  = bus.rom_data;
            end
            if (r_init_cnt == 6'(ROWS)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (bus.eat_valid) begin
               w_accept = 1'b1;
               if (w_in_range) begin
                  w_state_nxt = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (!bus.vid_req) begin
               w_mem_addr  = r_eat_row;
               w_state_nxt = ST_MOD;
            end
         end
         ST_MOD: begin
            w_state_nxt = (w_cell_pellet || w_cell_dot) ? ST_WR : ST_IDLE;
         end
         ST_WR: begin
            if (!bus.vid_req) begin
               w_eat_write = 1'b1;
               w_mem_we    = 1'b1;
               w_mem_addr  = r_eat_row;
               w_mem_wdata = r_row_data & w_clr_mask;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase

      if ((r_state != ST_INIT) && bus.vid_req) begin
         w_mem_addr = bus.vid_row;
      end

      // A new level aborts everything, including a pending eat write
      if (bus.level_start) begin
         w_state_nxt  = ST_INIT;
         w_mem_we     = 1'b0;
         w_init_write = 1'b0;
         w_eat_write  = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state        <= ST_INIT;
         r_init_cnt     <= '0;
         r_eat_row      <= '0;
         r_eat_col      <= '0;
         r_row_data     <= '0;
         r_pellet       <= 1'b0;
         r_score        <= '0;
         r_dots_left    <= '0;
         r_level_clear  <= 1'b0;
         r_pellet_eaten <= 1'b0;
         r_vid_rvalid   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_vid_rvalid   <= bus.vid_req && (r_state != ST_INIT);
         r_level_clear  <= 1'b0;
         r_pellet_eaten <= 1'b0;

         if (bus.level_start || (r_state != ST_INIT)) begin
            r_init_cnt <= '0;
         end else begin
            r_init_cnt <= r_init_cnt + 6'd1;
         end

         if (w_accept) begin
            r_eat_row <= bus.eat_row;
            r_eat_col <= bus.eat_col;
         end

         if (r_state == ST_MOD) begin
            r_row_data <= bus.mem_rdata;
            r_pellet   <= w_cell_pellet;
         end

         if (bus.level_start) begin
            r_dots_left <= '0;
         end else if (w_init_write) begin
            r_dots_left <= r_dots_left + w_row_pop;
         end else if (w_eat_write) begin
            r_score        <= w_score_nxt;
            r_pellet_eaten <= r_pellet;
            r_level_clear  <= (r_dots_left == 10'd1);
            if (r_dots_left != 10'd0) begin
               r_dots_left <= r_dots_left - 10'd1;
            end
         end
      end
   end

   assign bus.rom_addr     = r_init_cnt[4:0];
   assign bus.mem_addr     = w_mem_addr;
   assign bus.mem_we       = w_mem_we;
   assign bus.mem_wdata    = w_mem_wdata;
   assign bus.vid_rvalid   = r_vid_rvalid;
   assign bus.vid_rdata    = bus.mem_rdata;
   assign bus.eat_ready    = (r_state == ST_IDLE);
   assign bus.score        = r_score;
   assign bus.dots_left    = r_dots_left;
   assign bus.level_clear  = r_level_clear;
   assign bus.pellet_eaten = r_pellet_eaten;
   assign bus.init_busy    = (r_state == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_dot_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_ram_ctrl
// Brief    : Randomized self-checking bench for dot_ram_ctrl with a cell-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_ram_ctrl;
   localparam int ROWS    = 31;
   localparam int COLS    = 28;
   localparam int SCORE_W = 20;
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;

   logic Clk;
   logic Reset;

   dot_ram_ctrl_if #(.COLS(COLS), .SCORE_W(SCORE_W)) bus ();

   dot_ram_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .DOT_VALUE(10), .PELLET_VALUE(50), .SCORE_W(SCORE_W)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [2*COLS-1:0] rom [0:31];
   logic [2*COLS-1:0] ram [0:31];

   // External memories: ROM data and RAM read data both arrive one cycle late
   always @(posedge Clk) begin
      bus.rom_data <= rom[bus.rom_addr];
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int                we_cnt = 0;
   logic [4:0]        last_wr_addr;
   logic [2*COLS-1:0] last_wr_data;
   always @(negedge Clk) begin
      if (bus.mem_we) begin
         we_cnt       <= we_cnt + 1;
         last_wr_addr <= bus.mem_addr;
         last_wr_data <= bus.mem_wdata;
      end
   end

   // Cell-level reference model
   bit ref_pel [0:ROWS-1][0:COLS-1];
   bit ref_dot [0:ROWS-1][0:COLS-1];
   int ref_score;
   int ref_dots;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [2*COLS-1:0] model_row(input int r);
      logic [2*COLS-1:0] v;
      v = '0;
      for (int c = 0; c < COLS; c++) begin
         v[2*COLS-1-c] = ref_pel[r][c];
         v[COLS-1-c]   = ref_dot[r][c];
      end
      return v;
   endfunction

   task automatic load_model();
      ref_dots = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            ref_pel[r][c] = rom[r][2*COLS-1-c];
            ref_dot[r][c] = rom[r][COLS-1-c];
            if (ref_pel[r][c] || ref_dot[r][c]) ref_dots++;
         end
      end
   endtask

   // Entered in sweep cycle 0; runs the sweep to completion and checks it
   task automatic load_wait(input string tag);
      int n;
      int we0;
      we0 = we_cnt;
      n = 0;
      chk_eq({tag, "_rom_addr0"}, 64'(bus.rom_addr), 64'd0);
      while (bus.init_busy && n < 40) begin
         tick();
         n++;
      end
      chk_eq({tag, "_sweep_len"}, 64'(n), 64'(ROWS + 1));
      chk_eq({tag, "_eat_ready"}, 64'(bus.eat_ready), 64'd1);
      chk_eq({tag, "_writes"}, 64'(we_cnt - we0), 64'(ROWS));
      load_model();
      chk_eq({tag, "_dots_left"}, 64'(bus.dots_left), 64'(ref_dots));
      for (int r = 0; r < ROWS; r++) begin
         chk_eq({tag, "_ram_row"}, 64'(ram[r]), 64'(rom[r]));
      end
   endtask

   task automatic start_level(input string tag);
      bus.level_start = 1'b1;
      tick();
      bus.level_start = 1'b0;
      load_wait(tag);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.eat_ready && n < 100) begin
         tick();
         n++;
      end
      if (!bus.eat_ready) chk_eq("ready_timeout", 64'd0, 64'd1);
   endtask

   // Eat (r,c); video requests are held for nv cycles starting right after acceptance
   task automatic do_eat(input int r, input int c, input int nv, input int vr);
      int lat, np, nc, we0, exp_lat;
      bit inr, pel, dot, hit;
      logic [2*COLS-1:0] vrow;
      wait_ready();
      inr = (r < ROWS) && (c < COLS);
      pel = 1'b0;
      dot = 1'b0;
      if (inr) begin
         pel = ref_pel[r][c];
         dot = ref_dot[r][c];
      end
      hit  = inr && (pel || dot);
      vrow = model_row(vr);
      we0  = we_cnt;
      bus.eat_valid = 1'b1;
      bus.eat_row   = 5'(r);
      bus.eat_col   = 5'(c);
      tick();
      bus.eat_valid = 1'b0;
      np = 0;
      nc = 0;
      for (lat = 1; lat <= 60; lat++) begin
         bus.vid_req = (lat <= nv);
         bus.vid_row = 5'(vr);
         #1;
         if (lat >= 2 && lat <= nv + 1) begin
            chk_eq("vid_rvalid", 64'(bus.vid_rvalid), 64'd1);
            chk_eq("vid_rdata", 64'(bus.vid_rdata), 64'(vrow));
         end
         np += int'(bus.pellet_eaten);
         nc += int'(bus.level_clear);
         if (bus.eat_ready) break;
         tick();
      end
      bus.vid_req = 1'b0;
      if (lat > 60) chk_eq("eat_timeout", 64'd0, 64'd1);

      if (hit) begin
         ref_score = ref_score + (pel ? 50 : 10);
         if (ref_score > SCORE_MAX) ref_score = SCORE_MAX;
         ref_dots--;
         ref_pel[r][c] = 1'b0;
         ref_dot[r][c] = 1'b0;
      end
      exp_lat = hit ? 4 + nv : 3 + nv;
      if (inr) chk_eq("eat_latency", 64'(lat), 64'(exp_lat));
      chk_eq("eat_score", 64'(bus.score), 64'(ref_score));
      chk_eq("eat_dots_left", 64'(bus.dots_left), 64'(ref_dots));
      chk_eq("eat_writes", 64'(we_cnt - we0), 64'(hit));
      if (hit) begin
         chk_eq("eat_wr_addr", 64'(last_wr_addr), 64'(r));
         chk_eq("eat_wr_data", 64'(last_wr_data), 64'(model_row(r)));
      end
      tick();
      np += int'(bus.pellet_eaten);
      nc += int'(bus.level_clear);
      chk_eq("pellet_pulse", 64'(np), 64'(hit && pel));
      chk_eq("clear_pulse", 64'(nc), 64'(hit && (ref_dots == 0)));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      logic [63:0] a, b, d;
      for (int r = 0; r < 32; r++) begin
         rom[r] = '0;
         ram[r] = '0;
      end
      // Each of these rows holds 24 cells; the two pellet cells overlap dots
      rom[3]  = {28'h4000002, 28'h7FF9FFE};
      rom[23] = {28'h4000002, 28'h7FF9FFE};
      ref_score = 0;
      bus.level_start = 1'b0;
      bus.vid_req     = 1'b0;
      bus.vid_row     = '0;
      bus.eat_valid   = 1'b0;
      bus.eat_row     = '0;
      bus.eat_col     = '0;

      Reset = 1'b1;
      repeat (3) tick();
      chk_eq("rst_score", 64'(bus.score), 64'd0);
      chk_eq("rst_dots_left", 64'(bus.dots_left), 64'd0);
      chk_eq("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk_eq("rst_eat_ready", 64'(bus.eat_ready), 64'd0);
      chk_eq("rst_vid_rvalid", 64'(bus.vid_rvalid), 64'd0);
      chk_eq("rst_level_clear", 64'(bus.level_clear), 64'd0);
      chk_eq("rst_pellet_eaten", 64'(bus.pellet_eaten), 64'd0);
      chk_eq("rst_init_busy", 64'(bus.init_busy), 64'd1);
      Reset = 1'b0;
      load_wait("load0");
      chk_eq("load0_dots_48", 64'(bus.dots_left), 64'd48);

      do_eat(3, 1, 0, 0);   // pellet and dot both set: pellet value only
      do_eat(3, 2, 0, 0);   // dot only
      do_eat(3, 2, 0, 0);   // already empty
      do_eat(23, 5, 5, 3);  // video stalls the read for 5 cycles
      do_eat(31, 4, 0, 0);  // row out of range
      do_eat(3, 30, 0, 0);  // column out of range

      // New level requested while the eat sits in WR
      wait_ready();
      bus.eat_valid = 1'b1;
      bus.eat_row   = 5'd23;
      bus.eat_col   = 5'd10;
      tick();
      bus.eat_valid = 1'b0;
      tick();
      tick();
      we0 = we_cnt;
      bus.level_start = 1'b1;
      #1;
      chk_eq("ls_mem_we", 64'(bus.mem_we), 64'd0);
      tick();
      bus.level_start = 1'b0;
      chk_eq("ls_no_write", 64'(we_cnt - we0), 64'd0);
      chk_eq("ls_init_busy", 64'(bus.init_busy), 64'd1);
      chk_eq("ls_dots_left", 64'(bus.dots_left), 64'd0);
      chk_eq("ls_score", 64'(bus.score), 64'(ref_score));
      load_wait("ls");

      // Sparse random maze, random eats, then eat everything left
      for (int r = 0; r < ROWS; r++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         d = {$urandom, $urandom};
         rom[r] = 56'(a & b & d);
      end
      start_level("load_rand");
      for (int i = 0; i < 40; i++) begin
         do_eat(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, ROWS - 1)));
      end
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (ref_pel[r][c] || ref_dot[r][c]) begin
               do_eat(r, c, int'($urandom_range(0, 1)), int'($urandom_range(0, ROWS - 1)));
            end
         end
      end
      chk_eq("final_dots_left", 64'(bus.dots_left), 64'd0);
      chk_eq("final_score", 64'(bus.score), 64'(ref_score));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
